// File: rtl/vc_ingress_pkg.sv
// Shared constants for the VC ingress path: word width, VC encoding and FIFO sizing.
// Reused by the downstream arbiter and the D0/D1 output FIFOs.
package vc_ingress_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int ADDR_WIDTH = 4;
  localparam int VC_SEL_BIT = 4;
  localparam int AF_MARGIN  = 2;
  localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

endpackage : vc_ingress_pkg

// File: rtl/vc_ingress_fifo.sv
// First-word-fall-through sync FIFO for one virtual channel, with almost-full
// decode and a sticky overflow/underflow error flag.
module vc_fifo
  import vc_ingress_pkg::*;
#(
  parameter int DW        = DATA_WIDTH,
  parameter int AW        = ADDR_WIDTH,
  parameter int AF_MARGIN = vc_ingress_pkg::AF_MARGIN
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          error_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          error_q, error_d;
  logic          full, empty, doPush, doPop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign doPop  = pop_i & ~empty;
  assign doPush = push_i & (~full | doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    error_d = error_q | (push_i & full & ~pop_i) | (pop_i & empty);
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    unique case ({doPush, doPop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (reset_L && doPush) mem[wrPtr_q] <= data_i;
  end

  assign data_o        = empty ? '0 : mem[rdPtr_q];
  assign empty_o       = empty;
  assign almost_full_o = (count_q >= (AW+1)'(DEPTH - AF_MARGIN));
  assign error_o       = error_q;

endmodule : vc_fifo

// File: rtl/vc_ingress.sv
// Ingress stage: steers each source word into VC0 or VC1 by its class bit and
// buffers each class in its own FIFO, pausing the source when either nears full.
module vc_ingress
  import vc_ingress_pkg::*;
#(
  parameter int DW         = DATA_WIDTH,
  parameter int AW         = ADDR_WIDTH,
  parameter int SEL_BIT    = VC_SEL_BIT,
  parameter int AF_MARGIN  = vc_ingress_pkg::AF_MARGIN
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  input  logic          pop_VC0_fifo,
  input  logic          pop_VC1_fifo,
  output logic [DW-1:0] data_out_VC0,
  output logic [DW-1:0] data_out_VC1,
  output logic          empty_fifo_VC0,
  output logic          empty_fifo_VC1,
  output logic          almost_full_VC0,
  output logic          almost_full_VC1,
  output logic          pause_out,
  output logic          error_VC0,
  output logic          error_VC1
);

  vc_e  vcSel;
  logic pushVc0, pushVc1;

  assign vcSel   = vc_e'(data_in[SEL_BIT]);
  assign pushVc0 = valid_in & (vcSel == VC0);
  assign pushVc1 = valid_in & (vcSel == VC1);

  vc_fifo #(.DW(DW), .AW(AW), .AF_MARGIN(AF_MARGIN)) u_fifoVc0 (
    .clk           (clk),
    .reset_L       (reset_L),
    .push_i        (pushVc0),
    .pop_i         (pop_VC0_fifo),
    .data_i        (data_in),
    .data_o        (data_out_VC0),
    .empty_o       (empty_fifo_VC0),
    .almost_full_o (almost_full_VC0),
    .error_o       (error_VC0)
  );

  vc_fifo #(.DW(DW), .AW(AW), .AF_MARGIN(AF_MARGIN)) u_fifoVc1 (
    .clk           (clk),
    .reset_L       (reset_L),
    .push_i        (pushVc1),
    .pop_i         (pop_VC1_fifo),
    .data_i        (data_in),
    .data_o        (data_out_VC1),
    .empty_o       (empty_fifo_VC1),
    .almost_full_o (almost_full_VC1),
    .error_o       (error_VC1)
  );

  assign pause_out = almost_full_VC0 | almost_full_VC1;

endmodule : vc_ingress

// File: tb/tb_vc_ingress.sv
// Directed self-checking bench for vc_ingress: routing, fill/overflow, pointer
// wrap, simultaneous push/pop at the boundaries and mid-operation reset.
module tb_vc_ingress;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [5:0] data_in;
  logic       valid_in;
  logic       pop_VC0_fifo;
  logic       pop_VC1_fifo;
  logic [5:0] data_out_VC0;
  logic [5:0] data_out_VC1;
  logic       empty_fifo_VC0;
  logic       empty_fifo_VC1;
  logic       almost_full_VC0;
  logic       almost_full_VC1;
  logic       pause_out;
  logic       error_VC0;
  logic       error_VC1;

  int checks = 0;
  int errors = 0;

  vc_ingress dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .pop_VC0_fifo    (pop_VC0_fifo),
    .pop_VC1_fifo    (pop_VC1_fifo),
    .data_out_VC0    (data_out_VC0),
    .data_out_VC1    (data_out_VC1),
    .empty_fifo_VC0  (empty_fifo_VC0),
    .empty_fifo_VC1  (empty_fifo_VC1),
    .almost_full_VC0 (almost_full_VC0),
    .almost_full_VC1 (almost_full_VC1),
    .pause_out       (pause_out),
    .error_VC0       (error_VC0),
    .error_VC1       (error_VC1)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then return #1 after it.
  task automatic applyStimulus(input logic v, input logic [5:0] d,
                               input logic p0, input logic p1);
    valid_in     = v;
    data_in      = d;
    pop_VC0_fifo = p0;
    pop_VC1_fifo = p1;
    @(posedge clk);
    #1;
    valid_in     = 1'b0;
    data_in      = 6'h00;
    pop_VC0_fifo = 1'b0;
    pop_VC1_fifo = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset(input int cycles);
    reset_L = 1'b0;
    repeat (cycles) applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_L      = 1'b0;
    data_in      = 6'h00;
    valid_in     = 1'b0;
    pop_VC0_fifo = 1'b0;
    pop_VC1_fifo = 1'b0;

    // Reset then idle
    doReset(2);
    checkOutput("rst_empty0", empty_fifo_VC0, 1);
    checkOutput("rst_empty1", empty_fifo_VC1, 1);
    checkOutput("rst_pause", pause_out, 0);
    checkOutput("rst_af0", almost_full_VC0, 0);
    checkOutput("rst_af1", almost_full_VC1, 0);
    checkOutput("rst_err0", error_VC0, 0);
    checkOutput("rst_err1", error_VC1, 0);
    checkOutput("rst_dout0", data_out_VC0, 8'h00);
    checkOutput("rst_dout1", data_out_VC1, 8'h00);

    // Routing by bit 4
    applyStimulus(1'b1, 6'h05, 1'b0, 1'b0);
    checkOutput("route_head0", data_out_VC0, 8'h05);
    checkOutput("route_empty0", empty_fifo_VC0, 0);
    checkOutput("route_empty1_still", empty_fifo_VC1, 1);
    applyStimulus(1'b1, 6'h15, 1'b0, 1'b0);
    checkOutput("route_head1", data_out_VC1, 8'h15);
    checkOutput("route_head0_kept", data_out_VC0, 8'h05);
    applyStimulus(1'b0, 6'h00, 1'b1, 1'b1);
    checkOutput("route_pop_empty0", empty_fifo_VC0, 1);
    checkOutput("route_pop_empty1", empty_fifo_VC1, 1);
    checkOutput("route_err0", error_VC0, 0);
    checkOutput("route_err1", error_VC1, 0);

    // Fill VC0 to almost-full, then full, then overflow
    for (int i = 0; i < 14; i++) begin
      if (i == 13) checkOutput("fill_af0_at13", almost_full_VC0, 0);
      applyStimulus(1'b1, 6'(i), 1'b0, 1'b0);
    end
    checkOutput("fill_af0_at14", almost_full_VC0, 1);
    checkOutput("fill_pause_at14", pause_out, 1);
    applyStimulus(1'b1, 6'h0E, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h0F, 1'b0, 1'b0);
    checkOutput("fill_err0_full", error_VC0, 0);
    applyStimulus(1'b1, 6'h2A, 1'b0, 1'b0);
    checkOutput("overflow_err0", error_VC0, 1);
    checkOutput("overflow_err1", error_VC1, 0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain0_%0d", i), data_out_VC0, 8'(i));
      applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
    end
    checkOutput("drain0_empty", empty_fifo_VC0, 1);
    checkOutput("drain0_af", almost_full_VC0, 0);
    checkOutput("drain0_pause", pause_out, 0);
    checkOutput("drain0_err_sticky", error_VC0, 1);

    // Pointer wrap on VC1
    doReset(1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++)
        applyStimulus(1'b1, 6'((pass == 0 ? 8'h10 : 8'h30) + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
        checkOutput($sformatf("wrap_p%0d_%0d", pass, i), data_out_VC1,
                    8'((pass == 0 ? 8'h10 : 8'h30) + i));
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b1);
      end
    end
    checkOutput("wrap_empty1", empty_fifo_VC1, 1);
    checkOutput("wrap_err1", error_VC1, 0);

    // VC1 full: push and pop in the same cycle
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 6'(8'h30 + i), 1'b0, 1'b0);
    checkOutput("full1_af", almost_full_VC1, 1);
    applyStimulus(1'b1, 6'h1F, 1'b0, 1'b1);
    checkOutput("full1_simul_err", error_VC1, 0);
    checkOutput("full1_simul_head", data_out_VC1, 8'h31);
    checkOutput("full1_simul_af", almost_full_VC1, 1);
    for (int i = 1; i < 16; i++) begin
      checkOutput($sformatf("full1_drain_%0d", i), data_out_VC1, 8'(8'h30 + i));
      applyStimulus(1'b0, 6'h00, 1'b0, 1'b1);
    end
    checkOutput("full1_last_word", data_out_VC1, 8'h1F);
    applyStimulus(1'b0, 6'h00, 1'b0, 1'b1);
    checkOutput("full1_final_empty", empty_fifo_VC1, 1);
    checkOutput("full1_final_err", error_VC1, 0);

    // VC0 empty: push and pop in the same cycle
    checkOutput("empty0_pre_err", error_VC0, 0);
    applyStimulus(1'b1, 6'h01, 1'b1, 1'b0);
    checkOutput("empty0_simul_err", error_VC0, 1);
    checkOutput("empty0_simul_head", data_out_VC0, 8'h01);
    checkOutput("empty0_simul_nonempty", empty_fifo_VC0, 0);
    applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
    checkOutput("empty0_count_was1", empty_fifo_VC0, 1);

    // Reset mid-operation
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 6'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 6'h00, 1'b0, 1'b1);
    checkOutput("mid_err1_set", error_VC1, 1);
    checkOutput("mid_head0", data_out_VC0, 8'h00);
    reset_L = 1'b0;
    applyStimulus(1'b1, 6'h07, 1'b0, 1'b0);
    reset_L = 1'b1;
    checkOutput("mid_empty0", empty_fifo_VC0, 1);
    checkOutput("mid_dout0", data_out_VC0, 8'h00);
    checkOutput("mid_err0", error_VC0, 0);
    checkOutput("mid_err1", error_VC1, 0);
    applyStimulus(1'b1, 6'h0A, 1'b0, 1'b0);
    checkOutput("mid_new_head", data_out_VC0, 8'h0A);
    applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
    checkOutput("mid_new_empty", empty_fifo_VC0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vc_ingress

// File: doc/vc_ingress.md
Name: vc_ingress

Overview:
- Ingress stage directly upstream of the VC arbiter / D0-D1 output stage.
- Accepts one 6-bit word per cycle from the source and classifies it into virtual channel VC0 or VC1 by a class bit.
- Buffers each class in its own FIFO.
- Exposes head data, empty flags and pop inputs to the downstream arbiter, and a pause signal back to the source.

Parameters:
- data_width, 6, word width.
- address_width, 4, FIFO pointer width; depth = 2**address_width = 16 per VC.
- vc_sel_bit, 4, bit index of data_in that selects the VC (0 -> VC0, 1 -> VC1).
- af_margin, 2, almost_full asserts when count >= depth - af_margin (default 14).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_L  in  1  synchronous reset, active-low.
- data_in  in  data_width  word from source.
- valid_in  in  1  data_in valid this cycle.
- pop_VC0_fifo  in  1  arbiter pops VC0 head.
- pop_VC1_fifo  in  1  arbiter pops VC1 head.
- data_out_VC0  out  data_width  VC0 head word.
- data_out_VC1  out  data_width  VC1 head word.
- empty_fifo_VC0  out  1  VC0 holds 0 entries.
- empty_fifo_VC1  out  1  VC1 holds 0 entries.
- almost_full_VC0  out  1  VC0 count >= depth - af_margin.
- almost_full_VC1  out  1  VC1 count >= depth - af_margin.
- pause_out  out  1  almost_full_VC0 | almost_full_VC1, to source.
- error_VC0  out  1  sticky overflow/underflow flag for VC0.
- error_VC1  out  1  sticky overflow/underflow flag for VC1.

Behaviour:
- Reset: while reset_L=0 at a clk edge, all pointers and counts are 0 and error flags are 0. Inputs are ignored during reset.
- Outputs during and after reset: empty_fifo_VCx=1, almost_full_VCx=0, pause_out=0, data_out_VCx=0.
- Routing (combinational): push_VC0 = valid_in & ~data_in[vc_sel_bit]; push_VC1 = valid_in & data_in[vc_sel_bit]. Exactly one FIFO or none is written per cycle. The word is stored unmodified, including the class bit.
- FIFO per VC: circular memory of depth entries with wr_ptr, rd_ptr (address_width bits, wrap at depth-1 -> 0) and count (address_width+1 bits, 0..depth).
- Write latency: a push at edge N makes empty_fifo_VCx deassert and the word appear on data_out_VCx after edge N (visible in cycle N+1).
- Read is first-word-fall-through: data_out_VCx = mem[rd_ptr] when count>0, else 0. Asserting pop_VCx in a cycle consumes the displayed word at that edge.
- Flags empty, almost_full and pause_out are combinational decodes of the registered count; no extra latency.
- Push, not full: write mem[wr_ptr], wr_ptr+1, count+1.
- Pop, not empty: rd_ptr+1, count-1.
- Push and pop same cycle, 0<count<depth: both happen, count unchanged.
- Push and pop when count=depth: both happen (pop frees a slot), count stays depth, no error.
- Push when count=depth without pop: word dropped, state unchanged, error_VCx set.
- Pop when count=0: ignored, error_VCx set. Push and pop when count=0: push happens, pop ignored, error_VCx set, count becomes 1.
- error_VCx is sticky until reset.
- pause_out is advisory. The source must stop within af_margin cycles; overflow beyond that is handled as above.
- Reset mid-operation: contents are discarded and pointers return to 0 at the reset edge. The mem array itself need not be cleared.

Decomposition:
- Shared package holds the data width, VC encoding constants (VC0=0, VC1=1), vc_sel_bit default and the FIFO depth/margin defaults, reused by the arbiter and D0/D1 FIFOs.
- One natural sub-module, vc_fifo: parameterised sync FIFO with push, pop, data, count, empty, almost_full and sticky error.
- vc_ingress is the routing decode plus two vc_fifo instances and the pause OR.

Test Plan:
- Reset then idle: reset_L=0 for 2 cycles, then 1 -> empty_fifo_VC0/VC1=1, pause_out=0, error=0, data_out=0.
- Routing: push 6'h05 (bit4=0) then 6'h15 (bit4=1) -> cycle after each push, VC0 head=6'h05 and VC1 head=6'h15; each FIFO count=1.
- Fill VC0 with 14 words 6'h00..6'h0D -> almost_full_VC0 and pause_out go 1 after the 14th push. 2 more pushes -> count=16. 17th push without pop -> dropped, error_VC0=1. Then 16 pops return 6'h00..6'h0F in order.
- Wrap-around: 10 pushes, 10 pops, 10 pushes, 10 pops on VC1 with incrementing data -> order preserved across pointer wrap, no error.
- Simultaneous: VC1 full, push 6'h1F plus pop same cycle -> count stays 16, no error, new word delivered last. VC0 empty, pop plus push 6'h01 -> error_VC0=1, count=1, head=6'h01.
- Reset mid-operation: VC0 holds 5 words, reset_L=0 one cycle -> empty_fifo_VC0=1, error_VC0=0, next push visible as head.
